// File: rtl/bcd_rtc_counter_pkg.sv
// Shared types, digit limits and helpers for the BCD real-time counter.
// The 12h helper returns {pm, ms, ls}; a 24h hour of 00 is shown as 12 AM.
package bcd_rtc_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_HR_MS      = 4'd2;
  localparam bcd_t MAX_HR_LS_AT_2 = 4'd3;
  localparam bcd_t MAX_MS_MINSEC  = 4'd5;
  localparam bcd_t MAX_LS         = 4'd9;

  function automatic logic bcd_time_valid(input bcd_t ms_hr, input bcd_t ls_hr,
                                          input bcd_t ms_min, input bcd_t ls_min,
                                          input bcd_t ms_sec, input bcd_t ls_sec,
                                          input logic chk_sec);
    logic ok;
    ok = (ms_hr <= MAX_HR_MS) && (ls_hr <= MAX_LS) &&
         !((ms_hr == MAX_HR_MS) && (ls_hr > MAX_HR_LS_AT_2)) &&
         (ms_min <= MAX_MS_MINSEC) && (ls_min <= MAX_LS);
    if (chk_sec) begin
      ok = ok && (ms_sec <= MAX_MS_MINSEC) && (ls_sec <= MAX_LS);
    end
    return ok;
  endfunction

  function automatic logic [8:0] hr24_to_12(input bcd_t ms, input bcd_t ls);
    logic [7:0] h;
    logic [7:0] h12;
    h   = 8'(ms) * 8'd10 + 8'(ls);
    h12 = h - 8'd12;
    if (h == 8'd0) begin
      return {1'b0, 4'd1, 4'd2};
    end else if (h < 8'd12) begin
      return {1'b0, ms, ls};
    end else if (h == 8'd12) begin
      return {1'b1, 4'd1, 4'd2};
    end else if (h < 8'd24) begin
      if (h12 >= 8'd10) return {1'b1, 4'd1, 4'(h12 - 8'd10)};
      else              return {1'b1, 4'd0, h12[3:0]};
    end else begin
      // Out-of-range hour: pass it through so it stays visible
      return {1'b0, ms, ls};
    end
  endfunction

endpackage

// File: rtl/bcd_rtc_counter_digit.sv
// Single BCD digit with load, clear and increment; wraps to 0 at or above MAX.
// An out-of-range digit is treated as a wrap point, so corruption self-heals.
module bcd_rtc_counter_digit
  import bcd_rtc_counter_pkg::*;
#(
  parameter bcd_t MAX = MAX_LS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  input  logic i_load,
  input  bcd_t i_load_val,
  output bcd_t o_digit,
  output logic o_carry
);

  bcd_t r_digit;
  logic w_wrap;

  assign w_wrap  = (r_digit >= MAX);
  assign o_carry = i_inc & w_wrap;
  assign o_digit = r_digit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_clr) begin
      r_digit <= '0;
    end else if (i_inc) begin
      r_digit <= w_wrap ? '0 : r_digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_rtc_counter.sv
// BCD real-time counter HH:MM[:SS], 24h state, validated load, 12h output decode,
// registered day-rollover and load-error pulses.
module bcd_rtc_counter
  import bcd_rtc_counter_pkg::*;
#(
  parameter bit HAS_SECONDS = 1'b0,
  parameter bit HAS_12H     = 1'b1,
  parameter bit LOAD_CHECK  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_load_new_c,
  input  logic [3:0] i_new_time_ms_hr,
  input  logic [3:0] i_new_time_ls_hr,
  input  logic [3:0] i_new_time_ms_min,
  input  logic [3:0] i_new_time_ls_min,
  input  logic [3:0] i_new_time_ms_sec,
  input  logic [3:0] i_new_time_ls_sec,
  input  logic       i_mode_12h,
  output logic [3:0] o_current_time_ms_hr,
  output logic [3:0] o_current_time_ls_hr,
  output logic [3:0] o_current_time_ms_min,
  output logic [3:0] o_current_time_ls_min,
  output logic [3:0] o_current_time_ms_sec,
  output logic [3:0] o_current_time_ls_sec,
  output logic       o_pm_flag,
  output logic       o_day_rollover,
  output logic       o_load_error
);

  logic       w_adv, w_load_ok, w_load;
  logic       w_sec_carry, w_ls_min_carry, w_ms_min_carry, w_ls_hr_carry, w_ms_hr_carry;
  logic       w_hr_wrap;
  bcd_t       w_ms_sec, w_ls_sec, w_ms_min, w_ls_min, w_ms_hr, w_ls_hr;
  logic [8:0] w_h12;
  logic       r_day_rollover, r_load_error;

  // A load cycle always swallows the tick, whether or not the load is accepted
  assign w_adv     = i_tick & ~i_load_new_c;
  assign w_load_ok = !LOAD_CHECK ||
                     bcd_time_valid(i_new_time_ms_hr, i_new_time_ls_hr, i_new_time_ms_min,
                                    i_new_time_ls_min, i_new_time_ms_sec, i_new_time_ls_sec,
                                    HAS_SECONDS);
  assign w_load    = i_load_new_c & w_load_ok;

  if (HAS_SECONDS) begin : g_sec
    logic w_ls_sec_carry;
    bcd_rtc_counter_digit #(.MAX(MAX_LS)) u_ls_sec (
      .i_clk(i_clk), .i_rst(i_reset), .i_inc(w_adv), .i_clr(1'b0), .i_load(w_load),
      .i_load_val(i_new_time_ls_sec), .o_digit(w_ls_sec), .o_carry(w_ls_sec_carry)
    );
    bcd_rtc_counter_digit #(.MAX(MAX_MS_MINSEC)) u_ms_sec (
      .i_clk(i_clk), .i_rst(i_reset), .i_inc(w_ls_sec_carry), .i_clr(1'b0), .i_load(w_load),
      .i_load_val(i_new_time_ms_sec), .o_digit(w_ms_sec), .o_carry(w_sec_carry)
    );
  end else begin : g_no_sec
    assign w_ls_sec    = '0;
    assign w_ms_sec    = '0;
    assign w_sec_carry = w_adv;
  end

  bcd_rtc_counter_digit #(.MAX(MAX_LS)) u_ls_min (
    .i_clk(i_clk), .i_rst(i_reset), .i_inc(w_sec_carry), .i_clr(1'b0), .i_load(w_load),
    .i_load_val(i_new_time_ls_min), .o_digit(w_ls_min), .o_carry(w_ls_min_carry)
  );
  bcd_rtc_counter_digit #(.MAX(MAX_MS_MINSEC)) u_ms_min (
    .i_clk(i_clk), .i_rst(i_reset), .i_inc(w_ls_min_carry), .i_clr(1'b0), .i_load(w_load),
    .i_load_val(i_new_time_ms_min), .o_digit(w_ms_min), .o_carry(w_ms_min_carry)
  );

  // Hour units limit drops to 3 once tens reach 2; that point clears the whole hour
  assign w_hr_wrap = w_ms_min_carry & (w_ms_hr >= MAX_HR_MS) & (w_ls_hr >= MAX_HR_LS_AT_2);

  bcd_rtc_counter_digit #(.MAX(MAX_LS)) u_ls_hr (
    .i_clk(i_clk), .i_rst(i_reset), .i_inc(w_ms_min_carry), .i_clr(w_hr_wrap), .i_load(w_load),
    .i_load_val(i_new_time_ls_hr), .o_digit(w_ls_hr), .o_carry(w_ls_hr_carry)
  );
  bcd_rtc_counter_digit #(.MAX(MAX_HR_MS)) u_ms_hr (
    .i_clk(i_clk), .i_rst(i_reset), .i_inc(w_ls_hr_carry), .i_clr(w_hr_wrap), .i_load(w_load),
    .i_load_val(i_new_time_ms_hr), .o_digit(w_ms_hr), .o_carry(w_ms_hr_carry)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_day_rollover <= 1'b0;
      r_load_error   <= 1'b0;
    end else begin
      r_day_rollover <= w_hr_wrap;
      r_load_error   <= i_load_new_c & ~w_load_ok;
    end
  end

  assign w_h12 = hr24_to_12(w_ms_hr, w_ls_hr);

  always_comb begin
    o_current_time_ms_hr = w_ms_hr;
    o_current_time_ls_hr = w_ls_hr;
    o_pm_flag            = 1'b0;
    if (HAS_12H && i_mode_12h) begin
      o_pm_flag            = w_h12[8];
      o_current_time_ms_hr = w_h12[7:4];
      o_current_time_ls_hr = w_h12[3:0];
    end
  end

  assign o_current_time_ms_min = w_ms_min;
  assign o_current_time_ls_min = w_ls_min;
  assign o_current_time_ms_sec = w_ms_sec;
  assign o_current_time_ls_sec = w_ls_sec;
  assign o_day_rollover        = r_day_rollover;
  assign o_load_error          = r_load_error;

  // Tens-of-hours carry has no consumer; the hour wrap is decoded directly
  logic w_unused;
  assign w_unused = w_ms_hr_carry;

endmodule

// File: tb/tb_bcd_rtc_counter.sv
// Directed bench: expected outputs are queued when stimulus is driven and popped after the edge.
// Instance 0 is minute-resolution, instance 1 carries seconds; both share the stimulus.
module tb_bcd_rtc_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic       mode_12h = 1'b0;
  logic [3:0] n_ms_hr = '0, n_ls_hr = '0, n_ms_min = '0, n_ls_min = '0;
  logic [3:0] n_ms_sec = '0, n_ls_sec = '0;

  logic [3:0] a_ms_hr, a_ls_hr, a_ms_min, a_ls_min, a_ms_sec, a_ls_sec;
  logic       a_pm, a_roll, a_lerr;
  logic [3:0] b_ms_hr, b_ls_hr, b_ms_min, b_ls_min, b_ms_sec, b_ls_sec;
  logic       b_pm, b_roll, b_lerr;

  always #5 clk = ~clk;

  bcd_rtc_counter #(.HAS_SECONDS(1'b0), .HAS_12H(1'b1), .LOAD_CHECK(1'b1)) u_dut_min (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_load_new_c(load),
    .i_new_time_ms_hr(n_ms_hr), .i_new_time_ls_hr(n_ls_hr),
    .i_new_time_ms_min(n_ms_min), .i_new_time_ls_min(n_ls_min),
    .i_new_time_ms_sec(n_ms_sec), .i_new_time_ls_sec(n_ls_sec), .i_mode_12h(mode_12h),
    .o_current_time_ms_hr(a_ms_hr), .o_current_time_ls_hr(a_ls_hr),
    .o_current_time_ms_min(a_ms_min), .o_current_time_ls_min(a_ls_min),
    .o_current_time_ms_sec(a_ms_sec), .o_current_time_ls_sec(a_ls_sec),
    .o_pm_flag(a_pm), .o_day_rollover(a_roll), .o_load_error(a_lerr)
  );

  bcd_rtc_counter #(.HAS_SECONDS(1'b1), .HAS_12H(1'b1), .LOAD_CHECK(1'b1)) u_dut_sec (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_load_new_c(load),
    .i_new_time_ms_hr(n_ms_hr), .i_new_time_ls_hr(n_ls_hr),
    .i_new_time_ms_min(n_ms_min), .i_new_time_ls_min(n_ls_min),
    .i_new_time_ms_sec(n_ms_sec), .i_new_time_ls_sec(n_ls_sec), .i_mode_12h(mode_12h),
    .o_current_time_ms_hr(b_ms_hr), .o_current_time_ls_hr(b_ls_hr),
    .o_current_time_ms_min(b_ms_min), .o_current_time_ls_min(b_ls_min),
    .o_current_time_ms_sec(b_ms_sec), .o_current_time_ls_sec(b_ls_sec),
    .o_pm_flag(b_pm), .o_day_rollover(b_roll), .o_load_error(b_lerr)
  );

  typedef struct {
    int unsigned sel;
    logic [26:0] val;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_roll = 0;

  function automatic logic [26:0] observe(input int unsigned sel);
    if (sel == 1) return {b_ms_hr, b_ls_hr, b_ms_min, b_ls_min, b_ms_sec, b_ls_sec,
                          b_pm, b_roll, b_lerr};
    return {a_ms_hr, a_ls_hr, a_ms_min, a_ls_min, a_ms_sec, a_ls_sec, a_pm, a_roll, a_lerr};
  endfunction

  // hh is the hour as it should appear on the outputs (already 12h-decoded where relevant)
  task automatic push(input int unsigned sel, input int hh, input int mm, input int ss,
                      input logic pm, input logic roll, input logic lerr, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
             pm, roll, lerr};
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [26:0] o;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb_q.pop_front();
      o = observe(e.sel);
      assert (o === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    n_ms_hr  = 4'(hh / 10);
    n_ls_hr  = 4'(hh % 10);
    n_ms_min = 4'(mm / 10);
    n_ls_min = 4'(mm % 10);
    n_ms_sec = 4'(ss / 10);
    n_ls_sec = 4'(ss % 10);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    load = 1'b0;
    tick = 1'b0;
  endtask

  initial begin
    int h;
    int m;

    // Reset state, both formats
    #3;
    push(0, 0, 0, 0, 0, 0, 0, "rst_24h");       check();
    push(1, 0, 0, 0, 0, 0, 0, "rst_sec");       check();
    mode_12h = 1'b1;
    #1;
    push(0, 12, 0, 0, 0, 0, 0, "rst_12h");      check();
    mode_12h = 1'b0;
    #8 reset = 1'b0;
    @(posedge clk);
    #1;

    // Minute mode: hour tens carry and full-day wrap
    set_time(9, 59, 0); load = 1'b1;
    push(0, 9, 59, 0, 0, 0, 0, "load_0959");    cycle(); check();
    tick = 1'b1;
    push(0, 10, 0, 0, 0, 0, 0, "tick_1000");    cycle(); check();
    set_time(23, 59, 0); load = 1'b1;
    push(0, 23, 59, 0, 0, 0, 0, "load_2359");   cycle(); check();
    tick = 1'b1;
    push(0, 0, 0, 0, 0, 1, 0, "wrap_min");      cycle(); check();
    push(0, 0, 0, 0, 0, 0, 0, "roll_1cyc");     cycle(); check();

    // Seconds mode wrap
    set_time(23, 59, 58); load = 1'b1;
    push(1, 23, 59, 58, 0, 0, 0, "load_sec");   cycle(); check();
    tick = 1'b1;
    push(1, 23, 59, 59, 0, 0, 0, "tick_59");    cycle(); check();
    tick = 1'b1;
    push(1, 0, 0, 0, 0, 1, 0, "wrap_sec");      cycle(); check();
    push(1, 0, 0, 0, 0, 0, 0, "roll_sec_1c");   cycle(); check();

    // Load validation
    set_time(12, 30, 0); load = 1'b1;
    push(0, 12, 30, 0, 0, 0, 0, "load_ok");     cycle(); check();
    set_time(24, 0, 0); load = 1'b1;
    push(0, 12, 30, 0, 0, 0, 1, "load_24");     cycle(); check();
    push(0, 12, 30, 0, 0, 0, 0, "lerr_1cyc");   cycle(); check();
    set_time(12, 60, 0); load = 1'b1;
    push(0, 12, 30, 0, 0, 0, 1, "load_60");     cycle(); check();
    set_time(12, 60, 0); load = 1'b1; tick = 1'b1;
    push(1, 12, 30, 0, 0, 0, 1, "rej_tick_sec"); cycle(); check();

    // 12h decode
    mode_12h = 1'b1;
    set_time(0, 15, 0); load = 1'b1;
    push(0, 12, 15, 0, 0, 0, 0, "h12_0015");    cycle(); check();
    set_time(12, 0, 0); load = 1'b1;
    push(0, 12, 0, 0, 1, 0, 0, "h12_1200");     cycle(); check();
    set_time(13, 5, 0); load = 1'b1;
    push(0, 1, 5, 0, 1, 0, 0, "h12_1305");      cycle(); check();
    set_time(23, 59, 0); load = 1'b1;
    push(0, 11, 59, 0, 1, 0, 0, "h12_2359");    cycle(); check();
    mode_12h = 1'b0;
    #1;
    push(0, 23, 59, 0, 0, 0, 0, "h24_back");    check();

    // Load beats tick
    set_time(5, 5, 0); load = 1'b1; tick = 1'b1;
    push(0, 5, 5, 0, 0, 0, 0, "load_tick");     cycle(); check();
    tick = 1'b1;
    push(0, 5, 6, 0, 0, 0, 0, "tick_0506");     cycle(); check();
    tick = 1'b1;
    push(0, 5, 7, 0, 0, 0, 0, "tick_0507");     cycle(); check();

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    push(0, 0, 0, 0, 0, 0, 0, "async_rst");     check();
    push(1, 0, 0, 0, 0, 0, 0, "async_rst_s");   check();
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Full day of minute ticks against a counting model
    h = 0;
    m = 0;
    for (int i = 0; i < 1440; i++) begin
      tick = 1'b1;
      m++;
      if (m == 60) begin
        m = 0;
        h++;
        if (h == 24) h = 0;
      end
      push(0, h, m, 0, 0, logic'(h == 0 && m == 0), 0, "day_tick");
      cycle();
      check();
      if (a_roll) n_roll++;
    end
    push(0, 0, 0, 0, 0, 0, 0, "day_end");       cycle(); check();
    n_cmp++;
    assert (n_roll == 1) else begin
      n_bad++;
      $error("FAIL day_roll_count observed=%0d expected=1", n_roll);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
